operand_loader: RTL
===================

Name: operand_loader

Overview:
- Sequencer directly upstream of the register file.
- On a start command it fetches 1-4 bytes from the byte-wide memory bus at consecutive addresses.
- It presents each fetched byte on mem_dest with the matching mem_dest_select, for exactly one cycle, so the register file captures it at the next edge.
- Word operands are big-endian: the high byte is at the lower address.

Parameters:
- ADDR_W, 17, width of the memory address; matches IP width.
- TIMEOUT, 15, maximum cycles to wait for mem_ack per byte; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  loader_types::load_mode  what to load (see Behaviour).
- addr  in  ADDR_W  address of the first byte.
- mem_req  out  1  read request; held until acked.
- mem_addr  out  ADDR_W  read address.
- mem_ack  in  1  mem_rdata valid this cycle.
- mem_rdata  in  8  read data.
- mem_dest_select  out  register_types::name  target register; NONE when idle.
- mem_dest  out  8  byte to write.
- busy  out  1  high from the cycle after start is accepted through the done/error cycle.
- done  out  1  one-cycle pulse, coincident with presentation of the last byte.
- error  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (rst_n=0 at posedge, including mid-operation):
  - state=IDLE, mem_req=0, mem_addr=0, mem_dest_select=NONE, mem_dest=0, busy=0, done=0, error=0, wait counter=0.
  - No partial byte is presented after reset.
- Byte sequences per mode:
  - LOAD_NONE: 0 bytes.
  - LOAD_M: M.
  - LOAD_V: V.
  - LOAD_OP0_BYTE: OP0, which zero-extends in the register file.
  - LOAD_OP0_WORD: OP0H, OP0L.
  - LOAD_OP1_BYTE: OP1.
  - LOAD_OP1_WORD: OP1H, OP1L.
  - LOAD_OPS_WORD: OP0H, OP0L, OP1H, OP1L.
- States: IDLE, FETCH, PRESENT, FINISH.
- IDLE:
  - On start=1, latch addr, mode and byte count, and set busy=1 next cycle.
  - LOAD_NONE goes to FINISH. Every other mode goes to FETCH with mem_req=1 and mem_addr=addr.
- FETCH:
  - mem_req=1 and mem_addr are stable until mem_ack.
  - On mem_ack=1, register mem_rdata into mem_dest and the target into mem_dest_select, clear mem_req, and go to PRESENT.
  - The ack is combinational with req; an ack in the first FETCH cycle is legal.
  - mem_ack is ignored whenever mem_req=0.
- PRESENT (exactly one cycle; mem_dest and mem_dest_select valid):
  - If bytes remain: mem_addr <= mem_addr+1, wrapping modulo 2^ADDR_W (0x1FFFF+1 = 0x00000); mem_req=1; go to FETCH.
  - If this was the last byte: done=1 this cycle; next state IDLE with busy=0 and mem_dest_select=NONE.
  - Consequence: one fetched byte costs a minimum of 2 cycles (ack cycle plus present cycle).
- FINISH (LOAD_NONE only): done=1 for one cycle, select stays NONE, then IDLE.
- Timeout (TIMEOUT>0):
  - The wait counter resets on entering FETCH and increments each FETCH cycle without ack.
  - When the counter reaches TIMEOUT with no ack: mem_req=0, error=1 for one cycle, busy drops in the following cycle, state goes to IDLE, and no byte is presented.
  - Bytes already presented remain written in the register file.
- start while busy=1 is ignored; mode and addr are sampled only at acceptance.
- mem_dest_select is NONE in every cycle except PRESENT; mem_dest holds its last value outside PRESENT.

Decomposition:
- Package loader_types: load_mode enum (LOAD_NONE, LOAD_M, LOAD_V, LOAD_OP0_BYTE, LOAD_OP0_WORD, LOAD_OP1_BYTE, LOAD_OP1_WORD, LOAD_OPS_WORD) and a state enum.
- register_types::name gains NONE if not already present; NONE decodes to "no write" in the register file.
- Mode-to-target lookup (mode, byte index -> register_types::name, plus byte count) is a pure function in loader_types.
- No sub-module is required.

Test Plan:
- LOAD_OP0_WORD, addr=0x00100, memory [0x100]=0x12, [0x101]=0x34, zero-wait ack:
  - Present OP0H/0x12, then OP0L/0x34 with done in the same cycle.
  - Register file ends with OP0=0x1234.
- LOAD_OP1_BYTE, addr=0x00020, data 0xA5, ack delayed 3 cycles:
  - mem_req is held 4 cycles with mem_addr stable.
  - Then OP1/0xA5 is presented with done; OP1=0x00A5.
- LOAD_OPS_WORD, addr=0x1FFFE, data 0x01, 0x02, 0x03, 0x04:
  - mem_addr sequence is 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
  - Result: OP0=0x0102, OP1=0x0304.
- LOAD_M, TIMEOUT=15, mem_ack never asserted:
  - error pulses after 15 FETCH cycles, mem_req drops, M is unchanged, busy=0 afterwards.
- LOAD_NONE start:
  - done pulses on the cycle after acceptance, with no mem_req and select NONE throughout.
  - A second start issued while busy is ignored.
- LOAD_OP0_WORD with rst_n=0 asserted in the PRESENT cycle of the first byte:
  - All outputs return to reset values.
  - The next start with LOAD_V loads V normally.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared types for the operand loader: register-file write targets,
// load modes, sequencer states and the mode-to-target lookup.
package register_types;
    typedef enum logic [3:0] {
        NONE, M, V, OP0, OP0H, OP0L, OP1, OP1H, OP1L
    } name;
endpackage

package loader_types;
    import register_types::*;

    typedef enum logic [2:0] {
        LOAD_NONE, LOAD_M, LOAD_V, LOAD_OP0_BYTE,
        LOAD_OP0_WORD, LOAD_OP1_BYTE, LOAD_OP1_WORD, LOAD_OPS_WORD
    } load_mode;

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, FINISH} state_t;

    function automatic logic [2:0] byte_count(load_mode m);
        case (m)
            LOAD_NONE:                   return 3'd0;
            LOAD_OP0_WORD, LOAD_OP1_WORD: return 3'd2;
            LOAD_OPS_WORD:               return 3'd4;
            default:                     return 3'd1;
        endcase
    endfunction

    // Word operands are big-endian, so the high half is fetched first.
    function automatic name byte_target(load_mode m, logic [1:0] idx);
        case (m)
            LOAD_M:        return M;
            LOAD_V:        return V;
            LOAD_OP0_BYTE: return OP0;
            LOAD_OP1_BYTE: return OP1;
            LOAD_OP0_WORD: return idx[0] ? OP0L : OP0H;
            LOAD_OP1_WORD: return idx[0] ? OP1L : OP1H;
            LOAD_OPS_WORD: begin
                case (idx)
                    2'd0:    return OP0H;
                    2'd1:    return OP0L;
                    2'd2:    return OP1H;
                    default: return OP1L;
                endcase
            end
            default:       return NONE;
        endcase
    endfunction
endpackage

// File: rtl/operand_loader_if.sv
// Byte-wide memory read bus between the operand loader and memory.
interface operand_loader_if #(parameter int ADDR_W = 17);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [7:0]        rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/operand_loader.sv
// Fetches 1-4 operand bytes from memory and presents each one for a single
// cycle to the register file, with done/error pulses and a fetch timeout.
module operand_loader
    import register_types::*;
    import loader_types::*;
#(
    parameter int ADDR_W  = 17,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  load_mode          mode,
    input  logic [ADDR_W-1:0] addr,
    operand_loader_if.master  mem,
    output name               mem_dest_select,
    output logic [7:0]        mem_dest,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state;
    load_mode          mode_q;
    logic [2:0]        count_q;
    logic [1:0]        idx_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              timeout_hit;
    logic [1:0]        last_idx;

    assign mem.req     = req_q;
    assign mem.addr    = addr_q;
    assign last_idx    = 2'(count_q - 3'd1);
    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            mode_q          <= LOAD_NONE;
            count_q         <= '0;
            idx_q           <= '0;
            wait_cnt        <= '0;
            req_q           <= 1'b0;
            addr_q          <= '0;
            mem_dest_select <= NONE;
            mem_dest        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    busy            <= 1'b0;
                    mem_dest_select <= NONE;
                    // busy is still high for the cycle after a timeout abort
                    if (start && !busy) begin
                        mode_q   <= mode;
                        count_q  <= byte_count(mode);
                        idx_q    <= '0;
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                        if (mode == LOAD_NONE) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            req_q  <= 1'b1;
                            addr_q <= addr;
                            state  <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (mem.ack) begin
                        mem_dest        <= mem.rdata;
                        mem_dest_select <= byte_target(mode_q, idx_q);
                        done            <= (idx_q == last_idx);
                        req_q           <= 1'b0;
                        state           <= PRESENT;
                    end else if (timeout_hit) begin
                        req_q    <= 1'b0;
                        error    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                PRESENT: begin
                    mem_dest_select <= NONE;
                    if (done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx_q    <= idx_q + 1'b1;
                        addr_q   <= addr_q + ADDR_W'(1);
                        req_q    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= FETCH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
